measdif_mc_axil: RTL

- Multi-channel cycle-difference measurement peripheral with an AXI4-Lite slave register interface.
- Each of NUM_CH channels counts clock cycles from a start pulse to a stop pulse, then captures the result.
- Flags completion and overflow, and raises an interrupt.
- Sits behind the PS AXI interconnect in the mnghw block design; it is the parametrised successor of the fixed 4-register measdif slave.

---
 rtl/measdif_mc_pkg.sv | 13 +
 rtl/measdif_ch.sv | 64 ++++++
 rtl/measdif_mc_axil.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/measdif_mc_pkg.sv
// rtl/measdif_mc_pkg.sv - register map, response codes and channel state type for measdif_mc_axil
package measdif_mc_pkg;
  localparam logic [31:0] REG_CTRL      = 32'h00;
  localparam logic [31:0] REG_STATUS    = 32'h04;
  localparam logic [31:0] REG_SCRATCH   = 32'h08;
  localparam logic [31:0] REG_ID        = 32'h0C;
  localparam logic [31:0] REG_DIFF_BASE = 32'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT_START, COUNTING} ch_state_e;
endpackage

// File: rtl/measdif_ch.sv
// rtl/measdif_ch.sv - one measurement channel: start/stop FSM, saturating counter, DIFF capture
module measdif_ch
  import measdif_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  output logic [CNT_W-1:0] diff,
  output logic             done_set,
  output logic             ovf_set
);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_NEAR = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ch_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             active;

  // Soft clear suppresses capture and flag events in the cycle it lands
  assign active   = enable && !clr && (state == COUNTING);
  assign done_set = active && stop;
  assign ovf_set  = active && !start && !stop && (cnt == CNT_NEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      diff  <= '0;
    end else if (!enable) begin
      state <= IDLE;
      cnt   <= '0;
      if (clr) diff <= '0;
    end else if (clr) begin
      state <= WAIT_START;
      cnt   <= '0;
      diff  <= '0;
    end else begin
      case (state)
        IDLE: state <= WAIT_START;
        WAIT_START: begin
          if (start) begin
            cnt   <= CNT_ONE;
            state <= COUNTING;
          end
        end
        COUNTING: begin
          if (stop) begin
            diff <= cnt;
            if (!start) state <= WAIT_START;
          end
          if (start) cnt <= CNT_ONE;
          else if (!stop && cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/measdif_mc_axil.sv
// rtl/measdif_mc_axil.sv - AXI4-Lite multi-channel cycle-difference measurement peripheral
module measdif_mc_axil
  import measdif_mc_pkg::*;
#(
  parameter int          NUM_CH = 4,
  parameter int          CNT_W  = 32,
  parameter int          ADDR_W = 7,
  parameter logic [31:0] IP_ID  = 32'h4D44_0200
) (
  input  logic              s00_axi_aclk,
  input  logic              s00_axi_areset,
  input  logic [ADDR_W-1:0] s00_axi_awaddr,
  input  logic [2:0]        s00_axi_awprot,
  input  logic              s00_axi_awvalid,
  output logic              s00_axi_awready,
  input  logic [31:0]       s00_axi_wdata,
  input  logic [3:0]        s00_axi_wstrb,
  input  logic              s00_axi_wvalid,
  output logic              s00_axi_wready,
  output logic [1:0]        s00_axi_bresp,
  output logic              s00_axi_bvalid,
  input  logic              s00_axi_bready,
  input  logic [ADDR_W-1:0] s00_axi_araddr,
  input  logic [2:0]        s00_axi_arprot,
  input  logic              s00_axi_arvalid,
  output logic              s00_axi_arready,
  output logic [31:0]       s00_axi_rdata,
  output logic [1:0]        s00_axi_rresp,
  output logic              s00_axi_rvalid,
  input  logic              s00_axi_rready,
  input  logic [NUM_CH-1:0] start_i,
  input  logic [NUM_CH-1:0] stop_i,
  output logic              irq
);
  localparam logic [31:0] ADDR_END  = REG_DIFF_BASE + 32'(4 * NUM_CH);
  localparam logic [31:0] CTRL_MASK = {2'b01, {(30-NUM_CH){1'b0}}, {NUM_CH{1'b1}}};

  logic             clk, rst;
  logic             wr_rdy, wr_en, wr_ok, soft_clr;
  logic [31:0]      wa, ra, bm, ctrl_q, scratch_q, rd_word;
  logic             rd_ok;
  logic [NUM_CH-1:0] done_q, ovf_q, done_set, ovf_set, done_w1c, ovf_w1c;
  logic [CNT_W-1:0] diff_all [NUM_CH];
  logic             unused;

  assign clk    = s00_axi_aclk;
  assign rst    = s00_axi_areset;
  assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign s00_axi_awready = wr_rdy;
  assign s00_axi_wready  = wr_rdy;

  assign wa       = 32'({s00_axi_awaddr[ADDR_W-1:2], 2'b00});
  assign ra       = 32'({s00_axi_araddr[ADDR_W-1:2], 2'b00});
  assign wr_en    = wr_rdy && s00_axi_awvalid && s00_axi_wvalid;
  assign wr_ok    = wa < ADDR_END;
  assign bm       = {{8{s00_axi_wstrb[3]}}, {8{s00_axi_wstrb[2]}},
                     {8{s00_axi_wstrb[1]}}, {8{s00_axi_wstrb[0]}}};
  assign soft_clr = wr_en && (wa == REG_CTRL) && s00_axi_wstrb[3] && s00_axi_wdata[31];

  // W1C only touches bits whose byte lane is strobed
  always_comb begin
    done_w1c = '0;
    ovf_w1c  = '0;
    if (wr_en && wa == REG_STATUS) begin
      done_w1c = s00_axi_wdata[NUM_CH-1:0] & bm[NUM_CH-1:0];
      ovf_w1c  = s00_axi_wdata[16 +: NUM_CH] & bm[16 +: NUM_CH];
    end
  end

  always_comb begin
    rd_word = '0;
    rd_ok   = 1'b1;
    case (ra)
      REG_CTRL:    rd_word = ctrl_q;
      REG_STATUS:  rd_word = 32'(done_q) | (32'(ovf_q) << 16);
      REG_SCRATCH: rd_word = scratch_q;
      REG_ID:      rd_word = IP_ID;
      default: begin
        rd_ok = ra < ADDR_END;
        for (int c = 0; c < NUM_CH; c++)
          if (ra == REG_DIFF_BASE + 32'(4 * c)) rd_word = 32'(diff_all[c]);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_rdy          <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= RESP_OKAY;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
      s00_axi_rresp   <= RESP_OKAY;
      ctrl_q          <= '0;
      scratch_q       <= '0;
      done_q          <= '0;
      ovf_q           <= '0;
      irq             <= 1'b0;
    end else begin
      wr_rdy <= s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid && !wr_rdy;
      if (wr_en) begin
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wa == REG_CTRL)
          ctrl_q <= ((ctrl_q & ~bm) | (s00_axi_wdata & bm)) & CTRL_MASK;
        if (wa == REG_SCRATCH)
          scratch_q <= (scratch_q & ~bm) | (s00_axi_wdata & bm);
      end else if (s00_axi_bvalid && s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end

      s00_axi_arready <= s00_axi_arvalid && !s00_axi_rvalid && !s00_axi_arready;
      if (s00_axi_arready && s00_axi_arvalid) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_ok ? rd_word : 32'h0;
        s00_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s00_axi_rvalid && s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end

      // Hardware set beats a same-cycle W1C; soft clear beats both
      done_q <= soft_clr ? '0 : ((done_q & ~done_w1c) | done_set);
      ovf_q  <= soft_clr ? '0 : ((ovf_q & ~ovf_w1c) | ovf_set);
      irq    <= ctrl_q[30] && |done_q;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    measdif_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .enable   (ctrl_q[g]),
      .clr      (soft_clr),
      .start    (start_i[g]),
      .stop     (stop_i[g]),
      .diff     (diff_all[g]),
      .done_set (done_set[g]),
      .ovf_set  (ovf_set[g])
    );
  end
endmodule
